// File: rtl/nbit_serial_adder.sv
// Bit-serial N-bit adder: one full-adder slice plus a carry flip-flop, one bit per clock.
// Start/busy/done handshake; result and Z/N/C/V flags are registered on completion.
module nbit_serial_adder #(
   parameter int unsigned N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result,
   output logic [3:0]   flags
);

   localparam int unsigned CntW = $clog2(N);
   localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

   typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

   state_e          state_q, state_d;
   logic [N-1:0]    a_q, a_d;
   logic [N-1:0]    b_q, b_d;
   logic [N-1:0]    sum_q, sum_d;
   logic            carry_q, carry_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [N-1:0]    result_q, result_d;
   logic [3:0]      flags_q, flags_d;

   logic            sum_bit;
   logic            carry_out;
   logic [N-1:0]    sum_next;

   always_comb begin
      sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
      carry_out = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
      sum_next  = {sum_bit, sum_q[N-1:1]};

      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      sum_d    = sum_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      flags_d  = flags_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               sum_d   = '0;
               carry_d = 1'b0;
               cnt_d   = '0;
               state_d = StAdd;
            end
         end
         StAdd: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            sum_d   = sum_next;
            carry_d = carry_out;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
               result_d = sum_next;
               // Overflow: carry into the sign bit differs from carry out of it.
               flags_d  = {carry_q ^ carry_out, carry_out, sum_bit, (sum_next == '0)};
               state_d  = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         sum_q    <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         flags_q  <= 4'b0000;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sum_q    <= sum_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   assign busy   = (state_q == StAdd);
   assign done   = (state_q == StDone);
   assign result = result_q;
   assign flags  = flags_q;

endmodule

// File: tb/tb_nbit_serial_adder.sv
// Scoreboard bench for nbit_serial_adder: driver pushes expected results at each accept,
// monitor pops and compares whenever done is seen; also checks timing, holds and reset.
module tb_nbit_serial_adder;

   localparam int unsigned N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         busy;
   logic         done;
   logic [N-1:0] result;
   logic [3:0]   flags;

   typedef struct {
      logic [N-1:0] res;
      logic [3:0]   flg;
      int           acc;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;

   nbit_serial_adder #(.N(N)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .flags  (flags)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: plain integer arithmetic, unsigned and two's-complement views.
   function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y);
      exp_t e;
      int   ux, uy, sx, sy, usum, ssum;
      ux   = int'(x);
      uy   = int'(y);
      sx   = (ux >= (1 << (N - 1))) ? ux - (1 << N) : ux;
      sy   = (uy >= (1 << (N - 1))) ? uy - (1 << N) : uy;
      usum = ux + uy;
      ssum = sx + sy;
      e.res = N'(usum % (1 << N));
      e.flg[0] = (usum % (1 << N)) == 0;
      e.flg[1] = (usum % (1 << N)) >= (1 << (N - 1));
      e.flg[2] = usum >= (1 << N);
      e.flg[3] = (ssum > (1 << (N - 1)) - 1) || (ssum < -(1 << (N - 1)));
      e.acc = 0;
      return e;
   endfunction

   task automatic push_exp(input logic [N-1:0] x, input logic [N-1:0] y);
      exp_t e;
      e = model(x, y);
      e.acc = cyc;
      exp_q.push_back(e);
   endtask

   // Waits for the scoreboard to drain, then one more cycle for DONE -> IDLE.
   task automatic wait_drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 40) begin
         @(negedge clk);
         a = N'($urandom);
         b = N'($urandom);
         k++;
      end
      check("drain", 32'(exp_q.size()), 0);
      @(negedge clk);
   endtask

   // Caller is at a negedge with the DUT idle.
   task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y);
      a = x;
      b = y;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      push_exp(x, y);
      a = N'($urandom);
      b = N'($urandom);
      wait_drain();
   endtask

   // Monitor
   int           busy_run = 0;
   logic [N-1:0] prev_res = '0;
   logic [3:0]   prev_flg = '0;

   always begin
      exp_t e;
      @(posedge clk);
      #2;
      if (rst) begin
         check("reset_outputs", 32'({busy, done, flags, result}), 0);
         busy_run = 0;
         prev_res = '0;
         prev_flg = '0;
      end else begin
         if (busy) begin
            busy_run++;
         end else if (busy_run != 0) begin
            check("busy_len", 32'(busy_run), N);
            check("done_at_busy_end", 32'(done), 1);
            busy_run = 0;
         end
         if (done) begin
            check("pending_on_done", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("result", 32'(result), 32'(e.res));
               check("flags", 32'(flags), 32'(e.flg));
               check("latency", 32'(cyc - e.acc), N);
            end
         end else begin
            check("result_hold", 32'(result), 32'(prev_res));
            check("flags_hold", 32'(flags), 32'(prev_flg));
         end
         prev_res = result;
         prev_flg = flags;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1);
   end

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Idle with start low
      repeat (10) @(negedge clk);
      check("idle_outputs", 32'({busy, done, flags, result}), 0);

      run_op(4'd3, 4'd4);
      run_op(4'd8, 4'd8);
      run_op(4'd7, 4'd1);
      run_op(4'd15, 4'd1);

      // start held high: accepts only from IDLE, one every N+2 clocks
      a = 4'd2;
      b = 4'd3;
      start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         @(negedge clk);
         push_exp(4'd2, 4'd3);
         a = N'($urandom);
         b = N'($urandom);
         repeat (N) begin
            @(negedge clk);
            a = N'($urandom);
            b = N'($urandom);
         end
         @(negedge clk);
         a = 4'd2;
         b = 4'd3;
      end
      start = 1'b0;
      check("hold_drain", 32'(exp_q.size()), 0);

      // Reset during the second ADD cycle discards the operation
      run_op(4'd3, 4'd4);
      a = 4'd5;
      b = 4'd6;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("post_abort_outputs", 32'({busy, done, flags, result}), 0);

      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         run_op(N'($urandom), N'($urandom));
      end

      repeat (5) @(negedge clk);
      check("final_queue_empty", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/nbit_serial_adder.md
Name: nbit_serial_adder

Overview:
- Sequential, bit-serial counterpart to the team's combinational N-bit subtractor: computes a+b one bit per clock through a single full-adder slice with a carry flip-flop.
- Produces an N-bit sum plus a 4-bit flag word in the same flag-vector style as the subtractor.
- Sits beside the subtractor in the lab ALU datapath for area-constrained builds.
- Uses a start/busy/done handshake to the controlling FSM.

Parameters:
- N, 4, operand and result width in bits (N >= 2).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request; sampled only in IDLE
- a  input  N  operand A; captured on the accepting edge
- b  input  N  operand B; captured on the accepting edge
- busy  output  1  high while the ADD state is active
- done  output  1  one-cycle pulse when result/flags update
- result  output  N  registered sum, a+b mod 2^N
- flags  output  4  registered status: [0] Z zero, [1] N negative, [2] C carry-out, [3] V signed overflow

Behaviour:
- Interface (decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, flags=4'b0000, internal shift regs=0, carry=0, bit counter=0.
- FSM states are IDLE, ADD and DONE.
- IDLE:
  - On an edge with start=1: latch a and b into internal shift registers, set carry=0, counter=0, go to ADD.
  - With start=0: stay in IDLE.
- ADD:
  - Each edge: take the sum bit and carry from the LSBs of the shift regs and the carry FF.
  - Shift the sum bit into the internal sum register (MSB-in, right shift); update carry; increment counter.
  - On the N-th ADD edge (counter==N-1): load result from the completed sum, load flags, go to DONE.
- DONE: done=1 for exactly one cycle; the next edge returns to IDLE.
- Latency:
  - Start accepted at edge E0; result/flags/done update at edge EN (N clocks later); back in IDLE after EN+1.
  - Throughput: one operation per N+2 clocks.
- busy=1 exactly in ADD (N cycles). done=1 exactly in DONE.
- start is ignored in ADD and DONE. Operand changes after the accepting edge have no effect.
- result and flags hold the last completed values until the next completion. Nothing changes during ADD.
- Width/arithmetic rules:
  - result = (a+b) mod 2^N.
  - C = carry out of bit N-1.
  - Z = (result==0).
  - N = result[N-1].
  - V = (a[N-1]==b[N-1]) && (result[N-1]!=a[N-1]), using the latched operands.
- Simultaneous events: rst has priority over everything. start together with rst is ignored.
- Reset mid-operation (ADD or DONE): return to IDLE; all outputs cleared to reset values next cycle; the partial sum is discarded.

Test Plan:
- N=4, rst then a=3, b=4, start pulse -> busy high 4 cycles; done pulse 4 clocks after accept; result=7, flags=4'b0000.
- a=8, b=8 -> result=0, flags=4'b1101 (V, C, Z).
- a=7, b=1 -> result=8, flags=4'b1010 (V, N); then a=15, b=1 -> result=0, flags=4'b0101 (C, Z).
- Hold start=1 continuously with a=2, b=3 -> accepts only from IDLE; result=5, done every 6 clocks. Changing a/b during busy does not alter result.
- After a completed 3+4, start a=5, b=6 and assert rst on the 2nd ADD cycle -> next cycle busy=0, done=0, result=0, flags=0; no done pulse follows.
- After reset idle with start=0 for 10 cycles -> busy, done, result and flags stay 0.
